// File: rtl/lcd_spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : lcd_spi_pkg                                              |
// | Purpose   : Shared constants for the LCD SPI sink: ILI9341 opcodes,  |
// |             command-decoder state encoding and default coord width.  |
// | Ports     : none (package)                                           |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package lcd_spi_pkg;

   localparam int COORD_W_DEF = 9;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_PASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CASET = 3'd1;
   localparam logic [2:0] ST_PASET = 3'd2;
   localparam logic [2:0] ST_RAMWR = 3'd3;
   localparam logic [2:0] ST_SKIP  = 3'd4;

endpackage : lcd_spi_pkg
`default_nettype wire

// File: rtl/lcd_spi_sink_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : lcd_spi_sink_if                                          |
// | Purpose   : 4-wire display SPI bundle (cs, dc, sck, mosi).           |
// | Ports     : master drives all four lines, slave receives them.       |
// |             cs   chip select, active low                             |
// |             dc   0 = command, 1 = data                               |
// |             sck  serial clock (mode 0)                               |
// |             mosi serial data, MSB first                              |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface lcd_spi_sink_if;
   logic cs;
   logic dc;
   logic sck;
   logic mosi;

   modport master (output cs, dc, sck, mosi);
   modport slave  (input  cs, dc, sck, mosi);
endinterface : lcd_spi_sink_if
`default_nettype wire

// File: rtl/spi_byte_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : spi_byte_rx                                              |
// | Purpose   : Oversampling SPI mode-0 byte receiver. Synchronises the  |
// |             SPI lines into clk, detects sck rises while cs is low,   |
// |             shifts bits in MSB first and flags cs aborts mid-byte.   |
// | Ports     : clk, rst        clock / sync active-high reset           |
// |             spi             SPI lines (slave modport)                |
// |             byte_valid_o    one-cycle pulse per completed byte       |
// |             byte_data_o     completed byte, held until next pulse    |
// |             byte_dc_o       dc sampled with bit 0                    |
// |             frame_err_o     sticky: cs rose mid-byte                 |
// |             frame_abort_o   one-cycle pulse when that happens        |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module spi_byte_rx #(
   parameter int SYNC_STAGES = 2   // must be 2 or more
) (
   input  wire logic       clk,
   input  wire logic       rst,
   lcd_spi_sink_if.slave   spi,
   output logic            byte_valid_o,
   output logic [7:0]      byte_data_o,
   output logic            byte_dc_o,
   output logic            frame_err_o,
   output logic            frame_abort_o
);

   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] dc_sync_q;
   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;

   logic w_cs;
   logic w_dc;
   logic w_sck;
   logic w_mosi;
   logic w_sck_rise;
   logic w_cs_rise;

   logic sck_prev_q;
   logic cs_prev_q;
   logic rise_q;
   logic rise_mosi_q;
   logic rise_dc_q;
   logic cs_rise_q;

   logic [6:0] shift_q,      shift_d;
   logic [2:0] cnt_q,        cnt_d;
   logic       byte_valid_q, byte_valid_d;
   logic [7:0] byte_data_q,  byte_data_d;
   logic       byte_dc_q,    byte_dc_d;
   logic       frame_err_q,  frame_err_d;
   logic       abort_q,      abort_d;

   assign w_cs   = cs_sync_q[SYNC_STAGES-1];
   assign w_dc   = dc_sync_q[SYNC_STAGES-1];
   assign w_sck  = sck_sync_q[SYNC_STAGES-1];
   assign w_mosi = mosi_sync_q[SYNC_STAGES-1];

   assign w_sck_rise = w_sck & ~sck_prev_q & ~w_cs;
   assign w_cs_rise  = w_cs & ~cs_prev_q;

   // Synchronisers plus one registered edge-detect stage. The cs rise is
   // registered alongside the sck rise so both reach the bit counter in the
   // same pipeline stage; they can never coincide because an sck rise needs
   // cs low.
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync_q   <= '1;
         dc_sync_q   <= '0;
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         cs_prev_q   <= 1'b1;
         rise_q      <= 1'b0;
         rise_mosi_q <= 1'b0;
         rise_dc_q   <= 1'b0;
         cs_rise_q   <= 1'b0;
      end else begin
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   spi.cs};
         dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0],   spi.dc};
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0],  spi.sck};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
         sck_prev_q  <= w_sck;
         cs_prev_q   <= w_cs;
         rise_q      <= w_sck_rise;
         rise_mosi_q <= w_mosi;
         rise_dc_q   <= w_dc;
         cs_rise_q   <= w_cs_rise;
      end
   end

   always_comb begin
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      byte_valid_d = 1'b0;
      byte_data_d  = byte_data_q;
      byte_dc_d    = byte_dc_q;
      frame_err_d  = frame_err_q;
      abort_d      = 1'b0;
      if (cs_rise_q) begin
         // A cs rise on a byte boundary is harmless; mid-byte it aborts.
         if (cnt_q != 3'd0) begin
            frame_err_d = 1'b1;
            abort_d     = 1'b1;
            cnt_d       = 3'd0;
         end
      end else if (rise_q) begin
         shift_d = {shift_q[5:0], rise_mosi_q};
         cnt_d   = cnt_q + 3'd1;
         if (cnt_q == 3'd7) begin
            byte_valid_d = 1'b1;
            byte_data_d  = {shift_q, rise_mosi_q};
            byte_dc_d    = rise_dc_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q      <= '0;
         cnt_q        <= '0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= '0;
         byte_dc_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         byte_valid_q <= byte_valid_d;
         byte_data_q  <= byte_data_d;
         byte_dc_q    <= byte_dc_d;
         frame_err_q  <= frame_err_d;
         abort_q      <= abort_d;
      end
   end

   assign byte_valid_o  = byte_valid_q;
   assign byte_data_o   = byte_data_q;
   assign byte_dc_o     = byte_dc_q;
   assign frame_err_o   = frame_err_q;
   assign frame_abort_o = abort_q;

endmodule : spi_byte_rx
`default_nettype wire

// File: rtl/lcd_spi_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : lcd_spi_sink                                             |
// | Purpose   : Display-side SPI receiver. Deserialises bytes, decodes   |
// |             CASET/PASET/RAMWR and emits addressed RGB565 pixel       |
// |             writes inside the programmed window.                     |
// | Ports     : clk, rst        clock / sync active-high reset           |
// |             spi             SPI lines (slave modport)                |
// |             byte_valid/_data/_dc   raw byte stream                   |
// |             pix_valid/_x/_y/_data  pixel writes                      |
// |             frame_err       sticky: cs rose mid-byte                 |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module lcd_spi_sink
   import lcd_spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int COORD_W     = COORD_W_DEF,   // supported range 9..16
   parameter int X_RESET_END = 239,
   parameter int Y_RESET_END = 319
) (
   input  wire logic               clk,
   input  wire logic               rst,
   lcd_spi_sink_if.slave           spi,
   output logic                    byte_valid,
   output logic [7:0]              byte_data,
   output logic                    byte_dc,
   output logic                    pix_valid,
   output logic [COORD_W-1:0]      pix_x,
   output logic [COORD_W-1:0]      pix_y,
   output logic [15:0]             pix_data,
   output logic                    frame_err
);

   // Bits of the hi parameter byte that survive truncation to COORD_W.
   localparam int HI_W = COORD_W - 8;

   logic w_abort;

   spi_byte_rx #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rx (
      .clk           (clk),
      .rst           (rst),
      .spi           (spi),
      .byte_valid_o  (byte_valid),
      .byte_data_o   (byte_data),
      .byte_dc_o     (byte_dc),
      .frame_err_o   (frame_err),
      .frame_abort_o (w_abort)
   );

   logic [2:0]         state_q,    state_d;
   logic [1:0]         pcnt_q,     pcnt_d;
   logic [HI_W-1:0]    p0_q,       p0_d;
   logic [7:0]         p1_q,       p1_d;
   logic [HI_W-1:0]    p2_q,       p2_d;
   logic               hi_valid_q, hi_valid_d;
   logic [7:0]         hi_q,       hi_d;
   logic [COORD_W-1:0] xs_q, xs_d, xe_q, xe_d;
   logic [COORD_W-1:0] ys_q, ys_d, ye_q, ye_d;
   logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;

   logic               w_cmd;
   logic               w_data;
   logic [COORD_W-1:0] w_start;
   logic [COORD_W-1:0] w_end;
   logic               w_x_wrap;
   logic               w_y_wrap;

   assign w_cmd   = byte_valid & ~byte_dc;
   assign w_data  = byte_valid &  byte_dc;
   assign w_start = {p0_q, p1_q};
   assign w_end   = {p2_q, byte_data};

   // An inverted window collapses that axis to a single line, so the
   // cursor wraps on every step along it.
   assign w_x_wrap = (cur_x_q == xe_q) || (xs_q > xe_q);
   assign w_y_wrap = (cur_y_q == ye_q) || (ys_q > ye_q);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (w_abort) begin
         state_d = ST_IDLE;
      end else if (w_cmd) begin
         case (byte_data)
            CMD_CASET: state_d = ST_CASET;
            CMD_PASET: state_d = ST_PASET;
            CMD_RAMWR: state_d = ST_RAMWR;
            default:   state_d = ST_SKIP;
         endcase
      end else if (w_data && (state_q == ST_CASET || state_q == ST_PASET)
                   && pcnt_q == 2'd3) begin
         state_d = ST_IDLE;
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      pix_valid = w_data && (state_q == ST_RAMWR) && hi_valid_q;
      pix_x     = cur_x_q;
      pix_y     = cur_y_q;
      pix_data  = {hi_q, byte_data};
   end

   // ---------------- window, parameter and cursor datapath ----------------
   always_comb begin
      pcnt_d     = pcnt_q;
      p0_d       = p0_q;
      p1_d       = p1_q;
      p2_d       = p2_q;
      hi_valid_d = hi_valid_q;
      hi_d       = hi_q;
      xs_d       = xs_q;
      xe_d       = xe_q;
      ys_d       = ys_q;
      ye_d       = ye_q;
      cur_x_d    = cur_x_q;
      cur_y_d    = cur_y_q;
      if (w_abort) begin
         pcnt_d     = 2'd0;
         hi_valid_d = 1'b0;
      end else if (w_cmd) begin
         // Any command discards partial parameters and a dangling hi byte.
         pcnt_d     = 2'd0;
         hi_valid_d = 1'b0;
         if (byte_data == CMD_RAMWR) begin
            cur_x_d = xs_q;
            cur_y_d = ys_q;
         end
      end else if (w_data) begin
         case (state_q)
            ST_CASET, ST_PASET: begin
               pcnt_d = pcnt_q + 2'd1;
               case (pcnt_q)
                  2'd0:    p0_d = byte_data[HI_W-1:0];
                  2'd1:    p1_d = byte_data;
                  2'd2:    p2_d = byte_data[HI_W-1:0];
                  default: begin
                     if (state_q == ST_CASET) begin
                        xs_d = w_start;
                        xe_d = w_end;
                     end else begin
                        ys_d = w_start;
                        ye_d = w_end;
                     end
                  end
               endcase
            end
            ST_RAMWR: begin
               if (!hi_valid_q) begin
                  hi_d       = byte_data;
                  hi_valid_d = 1'b1;
               end else begin
                  hi_valid_d = 1'b0;
                  if (w_x_wrap) begin
                     cur_x_d = xs_q;
                     cur_y_d = w_y_wrap ? ys_q : cur_y_q + 1'b1;
                  end else begin
                     cur_x_d = cur_x_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_q     <= '0;
         p0_q       <= '0;
         p1_q       <= '0;
         p2_q       <= '0;
         hi_valid_q <= 1'b0;
         hi_q       <= '0;
         xs_q       <= '0;
         xe_q       <= COORD_W'(X_RESET_END);
         ys_q       <= '0;
         ye_q       <= COORD_W'(Y_RESET_END);
         cur_x_q    <= '0;
         cur_y_q    <= '0;
      end else begin
         pcnt_q     <= pcnt_d;
         p0_q       <= p0_d;
         p1_q       <= p1_d;
         p2_q       <= p2_d;
         hi_valid_q <= hi_valid_d;
         hi_q       <= hi_d;
         xs_q       <= xs_d;
         xe_q       <= xe_d;
         ys_q       <= ys_d;
         ye_q       <= ye_d;
         cur_x_q    <= cur_x_d;
         cur_y_q    <= cur_y_d;
      end
   end

endmodule : lcd_spi_sink
`default_nettype wire

// File: tb/tb_lcd_spi_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_lcd_spi_sink                                          |
// | Purpose   : Self-checking bench for lcd_spi_sink: directed vector    |
// |             table, hand-written corner sequences and randomised      |
// |             command streams against a window/cursor model.           |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tb_lcd_spi_sink;

   localparam int SYNC = 2;
   localparam int CW   = 9;
   localparam int PER  = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_dc;
   logic          pix_valid;
   logic [CW-1:0] pix_x;
   logic [CW-1:0] pix_y;
   logic [15:0]   pix_data;
   logic          frame_err;

   lcd_spi_sink_if spi ();

   lcd_spi_sink #(
      .SYNC_STAGES (SYNC),
      .COORD_W     (CW),
      .X_RESET_END (239),
      .Y_RESET_END (319)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .spi        (spi),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_dc    (byte_dc),
      .pix_valid  (pix_valid),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_data   (pix_data),
      .frame_err  (frame_err)
   );

   always #(PER/2) clk = ~clk;

   typedef struct {
      logic        dc;
      logic [7:0]  d;
      logic        pix;
      logic [8:0]  x;
      logic [8:0]  y;
      logic [15:0] pd;
   } vec_t;

   typedef struct {
      logic [7:0]  d;
      logic        dc;
      logic        pix;
      logic [8:0]  x;
      logic [8:0]  y;
      logic [15:0] pd;
      longint      t;
   } ev_t;

   ev_t    evq[$];
   longint riseq[$];
   int     stray_pix = 0;
   int     n_chk = 0;
   int     n_fail = 0;

   // Output monitor, sampling on the falling edge.
   always @(negedge clk) begin
      ev_t e;
      if (byte_valid) begin
         e.d = byte_data; e.dc = byte_dc; e.pix = pix_valid;
         e.x = pix_x; e.y = pix_y; e.pd = pix_data; e.t = $time;
         evq.push_back(e);
      end else if (pix_valid) begin
         stray_pix++;
      end
   end

   initial begin
      #(PER*200000);
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   function automatic vec_t mkv(input logic dcv, input logic [7:0] d, input logic pix,
                                input int x, input int y, input logic [15:0] pd);
      vec_t v;
      v.dc = dcv; v.d = d; v.pix = pix; v.x = 9'(x); v.y = 9'(y); v.pd = pd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic flush();
      evq.delete();
      riseq.delete();
   endtask

   task automatic cs_low();
      spi.cs = 1'b0;
      tick(4);
   endtask

   task automatic cs_high();
      spi.cs = 1'b1;
      tick(4);
   endtask

   // Sends the n most significant bits of d; records the time of bit 0's rise.
   task automatic send_bits(input logic dcv, input logic [7:0] d, input int n);
      spi.dc = dcv;
      for (int i = 7; i > 7 - n; i--) begin
         spi.mosi = d[i];
         tick(2);
         spi.sck = 1'b1;
         if (i == 0) riseq.push_back($time);
         tick(2);
         spi.sck = 1'b0;
      end
   endtask

   task automatic send_byte(input logic dcv, input logic [7:0] d);
      send_bits(dcv, d, 8);
      tick(6);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic check_zero(input string name);
      check({name, ".byte_valid"}, 32'(byte_valid), 0);
      check({name, ".byte_data"},  32'(byte_data),  0);
      check({name, ".byte_dc"},    32'(byte_dc),    0);
      check({name, ".pix_valid"},  32'(pix_valid),  0);
      check({name, ".pix_x"},      32'(pix_x),      0);
      check({name, ".pix_y"},      32'(pix_y),      0);
      check({name, ".pix_data"},   32'(pix_data),   0);
      check({name, ".frame_err"},  32'(frame_err),  0);
   endtask

   task automatic expect_ev(input string name, input vec_t v);
      ev_t    e;
      longint tr;
      int     waited = 0;
      while (evq.size() == 0 && waited < 40) begin
         tick(1);
         waited++;
      end
      if (evq.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: no byte_valid seen, required byte %02h", name, v.d);
         return;
      end
      e = evq.pop_front();
      check({name, ".byte_data"}, 32'(e.d),   32'(v.d));
      check({name, ".byte_dc"},   32'(e.dc),  32'(v.dc));
      check({name, ".pix_valid"}, 32'(e.pix), 32'(v.pix));
      if (riseq.size() > 0) begin
         tr = riseq.pop_front();
         check({name, ".latency"}, 32'(e.t - tr), 32'((SYNC + 2) * PER));
      end
      if (v.pix) begin
         check({name, ".pix_x"},    32'(e.x),  32'(v.x));
         check({name, ".pix_y"},    32'(e.y),  32'(v.y));
         check({name, ".pix_data"}, 32'(e.pd), 32'(v.pd));
      end
   endtask

   // Random command stream checked against a window model.
   task automatic random_txns(input int count);
      int mxs = 0, mxe = 239, mys = 0, mye = 319;
      for (int t = 0; t < count; t++) begin
         int         kind, n, w, h, k;
         logic [7:0] c;
         logic [7:0] d[10];
         vec_t       ex[$];
         kind = $urandom_range(0, 3);
         case (kind)
            0: c = 8'h2A;
            1: c = 8'h2B;
            2: c = 8'h2C;
            default: begin
               c = 8'($urandom);
               while (c >= 8'h2A && c <= 8'h2C) c = 8'($urandom);
            end
         endcase
         n = (kind < 2) ? $urandom_range(2, 5) : (kind == 2) ? $urandom_range(0, 9)
                                                             : $urandom_range(0, 3);
         for (int j = 0; j < 10; j++) begin
            if (kind < 2) d[j] = (j % 2 == 0) ? (8'($urandom) & 8'hFE)
                                              : 8'($urandom_range(0, 7));
            else          d[j] = 8'($urandom);
         end
         w = (mxe >= mxs) ? mxe - mxs + 1 : 1;
         h = (mye >= mys) ? mye - mys + 1 : 1;
         ex.push_back(mkv(0, c, 0, 0, 0, 0));
         for (int j = 0; j < n; j++) begin
            if (kind == 2 && (j % 2) == 1) begin
               k = j / 2;
               ex.push_back(mkv(1, d[j], 1, mxs + (k % w), mys + ((k / w) % h),
                                {d[j-1], d[j]}));
            end else begin
               ex.push_back(mkv(1, d[j], 0, 0, 0, 0));
            end
         end
         if (n >= 4 && kind == 0) begin mxs = {d[0][0], d[1]}; mxe = {d[2][0], d[3]}; end
         if (n >= 4 && kind == 1) begin mys = {d[0][0], d[1]}; mye = {d[2][0], d[3]}; end
         // Stimulus: byte-aligned cs toggles must not disturb decoding.
         send_byte(0, c);
         for (int j = 0; j < n; j++) begin
            if ($urandom_range(0, 3) == 0) begin cs_high(); cs_low(); end
            send_byte(1, d[j]);
         end
         foreach (ex[j]) expect_ev($sformatf("rnd%0d.b%0d", t, j), ex[j]);
      end
   endtask

   int   ex_x[10] = '{10, 11, 10, 11, 10, 11, 10, 11, 10, 11};
   int   ex_y[10] = '{5, 5, 6, 6, 5, 5, 6, 6, 5, 5};
   vec_t tbl[$];

   initial begin
      // Vector table for the windowed RAMWR sequence.
      tbl.push_back(mkv(0, 8'h2A, 0, 0, 0, 0));
      tbl.push_back(mkv(1, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mkv(1, 8'h0A, 0, 0, 0, 0));
      tbl.push_back(mkv(1, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mkv(1, 8'h0B, 0, 0, 0, 0));
      tbl.push_back(mkv(0, 8'h2B, 0, 0, 0, 0));
      tbl.push_back(mkv(1, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mkv(1, 8'h05, 0, 0, 0, 0));
      tbl.push_back(mkv(1, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mkv(1, 8'h06, 0, 0, 0, 0));
      tbl.push_back(mkv(0, 8'h2C, 0, 0, 0, 0));
      for (int k = 0; k < 10; k++) begin
         tbl.push_back(mkv(1, 8'hF8, 0, 0, 0, 0));
         tbl.push_back(mkv(1, 8'h00, 1, ex_x[k], ex_y[k], 16'hF800));
      end

      spi.cs = 1'b1; spi.dc = 1'b0; spi.sck = 1'b0; spi.mosi = 1'b0;
      rst = 1'b1;
      tick(3);
      check_zero("reset_held");
      rst = 1'b0;
      tick(2);
      check_zero("reset_released");

      // Single command byte framed by cs.
      flush();
      cs_low();
      send_byte(0, 8'h2C);
      cs_high();
      tick(4);
      expect_ev("single_cmd", mkv(0, 8'h2C, 0, 0, 0, 0));
      check("single_cmd.extra_bytes", 32'(evq.size()), 0);
      check("single_cmd.frame_err", 32'(frame_err), 0);

      // Windowed pixel stream from the table.
      cs_low();
      foreach (tbl[i]) begin
         send_byte(tbl[i].dc, tbl[i].d);
         expect_ev($sformatf("tbl%0d", i), tbl[i]);
      end

      // Reset window: pixels start at (0,0).
      pulse_rst();
      flush();
      send_byte(0, 8'h2C);
      send_byte(1, 8'h12); send_byte(1, 8'h34);
      send_byte(1, 8'hAB); send_byte(1, 8'hCD);
      expect_ev("dflt.cmd", mkv(0, 8'h2C, 0, 0, 0, 0));
      expect_ev("dflt.h0",  mkv(1, 8'h12, 0, 0, 0, 0));
      expect_ev("dflt.p0",  mkv(1, 8'h34, 1, 0, 0, 16'h1234));
      expect_ev("dflt.h1",  mkv(1, 8'hAB, 0, 0, 0, 0));
      expect_ev("dflt.p1",  mkv(1, 8'hCD, 1, 1, 0, 16'hABCD));

      // cs raised after 5 bits: frame error, no byte.
      send_bits(1, 8'hA5, 5);
      tick(2);
      cs_high();
      tick(10);
      check("abort.frame_err", 32'(frame_err), 1);
      check("abort.no_byte", 32'(evq.size()), 0);
      cs_low();
      send_byte(0, 8'h2A);
      expect_ev("abort.next", mkv(0, 8'h2A, 0, 0, 0, 0));
      check("abort.err_sticky", 32'(frame_err), 1);

      // Dangling hi byte dropped at a command; unknown opcode skips data.
      send_byte(0, 8'h2C);
      send_byte(1, 8'h12);
      send_byte(0, 8'h00);
      send_byte(1, 8'h34);
      send_byte(1, 8'h56);
      expect_ev("dangle.cmd", mkv(0, 8'h2C, 0, 0, 0, 0));
      expect_ev("dangle.hi",  mkv(1, 8'h12, 0, 0, 0, 0));
      expect_ev("dangle.nop", mkv(0, 8'h00, 0, 0, 0, 0));
      expect_ev("dangle.d0",  mkv(1, 8'h34, 0, 0, 0, 0));
      expect_ev("dangle.d1",  mkv(1, 8'h56, 0, 0, 0, 0));

      // Reset mid-CASET and mid-byte.
      send_byte(0, 8'h2A);
      send_byte(1, 8'h00);
      send_byte(1, 8'h05);
      send_bits(1, 8'hFF, 3);
      tick(2);
      pulse_rst();
      check_zero("midrst");
      cs_high();
      tick(6);
      check("midrst.no_err", 32'(frame_err), 0);
      flush();
      cs_low();
      send_byte(1, 8'h00);
      send_byte(1, 8'h07);
      expect_ev("midrst.ign0", mkv(1, 8'h00, 0, 0, 0, 0));
      expect_ev("midrst.ign1", mkv(1, 8'h07, 0, 0, 0, 0));
      send_byte(0, 8'h2C);
      expect_ev("midrst.ramwr", mkv(0, 8'h2C, 0, 0, 0, 0));
      for (int k = 0; k <= 240; k++) begin
         logic [15:0] v;
         v = 16'(k);
         send_byte(1, v[15:8]);
         send_byte(1, v[7:0]);
         expect_ev($sformatf("row.h%0d", k), mkv(1, v[15:8], 0, 0, 0, 0));
         expect_ev($sformatf("row.p%0d", k),
                   mkv(1, v[7:0], 1, (k < 240) ? k : 0, (k < 240) ? 0 : 1, v));
      end

      random_txns(25);

      cs_high();
      tick(10);
      check("final.stray_pix", 32'(stray_pix), 0);
      check("final.leftover", 32'(evq.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_lcd_spi_sink
`default_nettype wire
